// File: rtl/set_bit_encoder_pkg.sv
// Shared sizing and FSM state type for the set-bit encoder.
package set_bit_encoder_pkg;
  localparam int WIDTH = 128;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/set_bit_encoder_if.sv
// Load/emit handshake bundle. A beat transfers on any rising edge where valid and ready are both high.
// Producers hold valid and payload until ready is seen, and valid never depends on ready.
interface set_bit_encoder_if;
  import set_bit_encoder_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_empty;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_empty, beat_cnt
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_empty, beat_cnt
  );
endinterface

// File: rtl/set_bit_encoder_lse.sv
// Combinational lowest-set-bit encoder built as a log-depth pairwise tree.
module lowest_set_encoder
  import set_bit_encoder_pkg::*;
(
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Level l node n covers bits [n*2^l +: 2^l]; idx is the offset within that span.
  for (genvar l = 0; l <= IDX_W; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [N-1:0]     w_found;
    logic [IDX_W-1:0] w_idx [N];

    if (l == 0) begin : g_leaf
      assign w_found = i_vec;
      for (genvar n = 0; n < N; n++) begin : g_n
        assign w_idx[n] = '0;
      end
    end else begin : g_node
      for (genvar n = 0; n < N; n++) begin : g_n
        assign w_found[n] = g_lvl[l-1].w_found[2*n] | g_lvl[l-1].w_found[2*n+1];
        assign w_idx[n]   = g_lvl[l-1].w_found[2*n] ? g_lvl[l-1].w_idx[2*n]
                          : (g_lvl[l-1].w_idx[2*n+1] | (IDX_W'(1) << (l-1)));
      end
    end
  end

  assign o_found = g_lvl[IDX_W].w_found[0];
  assign o_idx   = g_lvl[IDX_W].w_idx[0];

endmodule

// File: rtl/set_bit_encoder.sv
// Serialises the set bits of a loaded vector into binary indices, lowest first, one per beat.
module set_bit_encoder
  import set_bit_encoder_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  set_bit_encoder_if.slave   bus
);

  state_t           r_state;
  logic [WIDTH-1:0] r_vec_q;
  logic             r_empty_q;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_emit;
  logic             w_last;

  lowest_set_encoder u_lse (
    .i_vec   (r_vec_q),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  assign w_emit = (r_state == EMIT);
  assign w_last = w_emit & (r_empty_q | ((r_vec_q & (r_vec_q - 1'b1)) == '0));

  assign bus.in_ready  = ~w_emit;
  assign bus.out_valid = w_emit;
  assign bus.out_idx   = (w_emit & w_found) ? w_idx : '0;
  assign bus.out_last  = w_last;
  assign bus.out_empty = w_emit & r_empty_q;
  assign bus.beat_cnt  = r_beat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vec_q    <= '0;
      r_empty_q  <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_vec_q    <= bus.in_vec;
            r_empty_q  <= (bus.in_vec == '0);
            r_beat_cnt <= '0;
            r_state    <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            r_vec_q <= r_vec_q & (r_vec_q - 1'b1);
            if (r_beat_cnt != CNT_W'(WIDTH))
              r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last) begin
              r_empty_q <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_bit_encoder.sv
// Directed and randomized checks of set_bit_encoder against a bit-scan reference model.
module tb_set_bit_encoder;
  import set_bit_encoder_pkg::*;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [IDX_W-1:0] exp_q[$];

  set_bit_encoder_if bus();

  set_bit_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  WIDTH'(bus.in_ready),  1);
    check({tag, "_out_valid"}, WIDTH'(bus.out_valid), 0);
    check({tag, "_out_idx"},   WIDTH'(bus.out_idx),   0);
    check({tag, "_out_last"},  WIDTH'(bus.out_last),  0);
    check({tag, "_out_empty"}, WIDTH'(bus.out_empty), 0);
    check({tag, "_beat_cnt"},  WIDTH'(bus.beat_cnt),  0);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_vec(input string tag, input logic [WIDTH-1:0] v,
                         input int stall_first, input int stall_pct);
    int k;
    int total;
    int beats;
    int cycles;
    exp_q.delete();
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) exp_q.push_back(IDX_W'(i));
    k = exp_q.size();
    if (k == 0) exp_q.push_back('0);
    total = exp_q.size();

    check({tag, "_load_ready"}, WIDTH'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_vec   = {$urandom, $urandom, $urandom, $urandom};

    beats  = 0;
    cycles = 0;
    while (beats < total && cycles < 2000) begin
      if (cycles < stall_first) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(99) >= stall_pct);
      @(negedge clk);
      check({tag, "_valid"},    WIDTH'(bus.out_valid), 1);
      check({tag, "_in_ready"}, WIDTH'(bus.in_ready),  0);
      check({tag, "_idx"},      WIDTH'(bus.out_idx),   WIDTH'(exp_q[0]));
      check({tag, "_last"},     WIDTH'(bus.out_last),  WIDTH'(beats == total - 1));
      check({tag, "_empty"},    WIDTH'(bus.out_empty), WIDTH'(k == 0));
      check({tag, "_cnt"},      WIDTH'(bus.beat_cnt),  WIDTH'(beats));
      @(posedge clk);
      if (bus.out_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
      #1;
      cycles++;
    end
    check({tag, "_beats_done"}, WIDTH'(beats), WIDTH'(total));
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_ready"}, WIDTH'(bus.in_ready),  1);
    check({tag, "_idle_valid"}, WIDTH'(bus.out_valid), 0);
    check({tag, "_final_cnt"},  WIDTH'(bus.beat_cnt),  WIDTH'(total));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    n_vec = 0;
    n_err = 0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_vec("single", 128'h1, 0, 0);

    v = '0; v[3] = 1'b1; v[64] = 1'b1; v[127] = 1'b1;
    run_vec("sparse", v, 0, 0);

    run_vec("zero", '0, 0, 0);

    v = '0; v[5] = 1'b1; v[9] = 1'b1;
    run_vec("bpress", v, 6, 0);

    run_vec("ones", '1, 0, 0);

    run_vec("top_bit", {1'b1, 127'b0}, 2, 0);

    for (int t = 0; t < 8; t++) begin
      v = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom}
        & {$urandom, $urandom, $urandom, $urandom};
      run_vec("rand", v, 0, 30);
    end

    // Reset mid-vector, asserted between clock edges.
    bus.in_valid  = 1'b1;
    bus.in_vec    = '1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("mid_cnt_before", WIDTH'(bus.beat_cnt), 10);
    rst = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec("after_rst", 128'h80, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/set_bit_encoder.md
# set_bit_encoder

Sequential encoder that is the inverse of the one-hot shift decoder: it accepts a 128-bit vector and returns the 7-bit index of every set bit, lowest first, one index per handshake. It sits on the return path from mask and one-hot logic, where positions must be turned back into binary indices. It also reports an explicit empty result and a running beat count.

## Interface
- WIDTH, 128, input vector width; must be a power of two.
- IDX_W, 7, index width; equals log2(WIDTH).
- CNT_W, 8, beat counter width; equals IDX_W+1 so it can hold WIDTH.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  vector to encode.
- out_valid  output  1  out_idx, out_last and out_empty are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDX_W  index of the lowest remaining set bit.
- out_last  output  1  current beat is the final beat for this vector.
- out_empty  output  1  loaded vector was all zeros; out_idx is 0 on this beat.
- beat_cnt  output  CNT_W  beats completed for the current vector.

## Operation
- Registers:
  - vec_q: WIDTH bits holding the remaining bits.
  - empty_q: set when the loaded vector was zero.
  - state: IDLE or EMIT.
  - beat_cnt.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: vec_q<=in_vec, empty_q<=(in_vec==0), beat_cnt<=0, state<=EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_idx = index of the lowest set bit of vec_q, or 0 when empty_q.
  - out_last = empty_q, or vec_q has exactly one bit set. Compute this as (vec_q & (vec_q-1))==0.
  - out_empty = empty_q.
  - On out_valid & out_ready: clear bit out_idx in vec_q (vec_q<=vec_q & (vec_q-1)) and increment beat_cnt, saturating at WIDTH.
  - If out_last, also clear empty_q and set state<=IDLE.
- Zero vector: produces exactly one beat with out_empty=1, out_idx=0, out_last=1. beat_cnt becomes 1 after that beat. The empty beat counts as a beat.
- in_vec is ignored while state=EMIT. in_valid held high is not consumed until the block returns to IDLE.
- Holding out_ready low in EMIT is legal. out_idx, out_last, out_empty and beat_cnt hold stable with no time limit.
- Index arithmetic is unsigned. Bit 0 maps to index 0 and bit WIDTH-1 maps to index WIDTH-1. There is no wrap.
- Asserting rst at any time, including mid-vector:
  - takes effect immediately;
  - forces state=IDLE, vec_q=0, empty_q=0, beat_cnt=0;
  - discards the in-progress vector.

## Timing
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0, beat_cnt=0.
- All outputs are decoded from registers only. There is no combinational path from in_* or out_ready to any output.
- Latency: an input handshake at edge N gives out_valid=1 with the first index during the cycle after N.
- Throughput: one index per cycle when out_ready is held high.
- Total occupancy for a vector with k set bits: one IDLE cycle for the load, plus max(k,1) EMIT cycles.
- After the out_last handshake, in_ready=1 in the following cycle. The next vector's first beat appears one cycle after it is accepted.
- Minimum cost is therefore one bubble cycle per vector. Load and emit are not overlapped.

## Structure
- Package set_bit_encoder_pkg holds:
  - WIDTH, IDX_W, CNT_W;
  - the state enum {IDLE, EMIT}.
- Sub-module lowest_set_encoder, purely combinational:
  - input WIDTH bits;
  - outputs IDX_W-bit index and a found flag;
  - implemented as a priority tree, lowest bit wins.
- The top level holds the FSM, vec_q, empty_q, beat_cnt and the out_last detect.

## Test plan
- Single bit: reset, load 128'h1 -> one beat with out_idx=0, out_last=1, out_empty=0. beat_cnt=1 afterwards; in_ready=1 the next cycle.
- Sparse vector: load with bits 3, 64 and 127 set, out_ready held high -> beats 3, 64, 127 on consecutive cycles. out_last only on 127; beat_cnt ends at 3.
- Zero vector: load 128'h0 -> exactly one beat with out_empty=1, out_idx=0, out_last=1; then IDLE.
- Backpressure: load with bits 5 and 9 set, out_ready=0 for 6 cycles -> out_idx stays 5 and out_last stays 0. After out_ready rises, idx 9 with out_last=1. in_ready stays 0 throughout.
- All ones: load with every bit set, out_ready high -> 128 back-to-back beats, idx 0..127, out_last only on 127, beat_cnt=128.
- Reset mid-vector: load with every bit set, assert rst after 10 beats, between clock edges -> outputs reach their reset values without waiting for a clock edge. After release, load 128'h80 -> single beat with idx 7.
